// File: rtl/pb_pkg.sv
// Shared constants and helpers for the pushbutton conditioning front end.
package pb_pkg;

   localparam int PB_NUM_DEFAULT        = 4;
   localparam int PB_TICK_DIV_1KHZ      = 49999;
   localparam int PB_SHIFT_LEN_DEFAULT  = 10;
   localparam int PB_HOLD_TICKS_DEFAULT = 1000;

   // Width of the shared tick divider.
   localparam int PB_DIV_W = 16;

   typedef logic [PB_NUM_DEFAULT-1:0] pb_vec_t;

   // Smallest counter width able to hold max_val.
   function automatic int pb_cnt_width(input int max_val);
      int w;
      w = 1;
      while ((1 << w) <= max_val) w++;
      return w;
   endfunction

endpackage

// File: rtl/pb_channel.sv
// One pushbutton: synchronizer, tick-sampled shift-register debounce, edge pulses.
// Optional long-press pulse when PB_HOLD_DETECT_EN is defined.
module pb_channel
   import pb_pkg::*;
#(
   parameter int SHIFT_LEN  = PB_SHIFT_LEN_DEFAULT,
   parameter int HOLD_TICKS = PB_HOLD_TICKS_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic button_n,
   output logic status,
   output logic pressed,
   output logic released,
   output logic held
);

   // Synchronizer stores the pressed polarity so that a cleared flop reads as released.
   logic [1:0]           sync;
   logic [SHIFT_LEN-1:0] shift_reg;
   logic                 status_buf;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync       <= '0;
         shift_reg  <= '0;
         status     <= 1'b0;
         status_buf <= 1'b0;
      end else begin
         sync <= {sync[0], ~button_n};
         if (tick) begin
            shift_reg <= {shift_reg[SHIFT_LEN-2:0], sync[1]};
         end
         status     <= |shift_reg;
         status_buf <= status;
      end
   end

   assign pressed  = status & ~status_buf;
   assign released = ~status & status_buf;

`ifdef PB_HOLD_DETECT_EN
   localparam int                HOLD_W   = pb_cnt_width(HOLD_TICKS);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_TICKS);

   logic [HOLD_W-1:0] hold_cnt;

   // Counter saturates at HOLD_MAX so the pulse cannot repeat until release.
   always_ff @(posedge clk) begin
      if (rst || !status) begin
         hold_cnt <= '0;
         held     <= 1'b0;
      end else if (tick && (hold_cnt != HOLD_MAX)) begin
         hold_cnt <= hold_cnt + 1'b1;
         held     <= (hold_cnt == (HOLD_MAX - 1'b1));
      end else begin
         held <= 1'b0;
      end
   end
`else
   assign held = 1'b0 & (HOLD_TICKS > 0);
`endif

endmodule

// File: rtl/pb_debounce_detect.sv
// Pushbutton front end: shared 1 kHz tick divider feeding NUM_PB debounce channels.
// Long-press detection is compiled in only when PB_HOLD_DETECT_EN is defined.
module pb_debounce_detect
   import pb_pkg::*;
#(
   parameter int NUM_PB     = PB_NUM_DEFAULT,
   parameter int TICK_DIV   = PB_TICK_DIV_1KHZ,
   parameter int SHIFT_LEN  = PB_SHIFT_LEN_DEFAULT,
   parameter int HOLD_TICKS = PB_HOLD_TICKS_DEFAULT
) (
   input  logic              CLOCK_50_I,
   input  logic              RESET_I,
   input  logic [NUM_PB-1:0] PUSH_BUTTON_N_I,
   output logic              TICK_1KHZ_O,
   output logic [NUM_PB-1:0] PB_STATUS_O,
   output logic [NUM_PB-1:0] PB_PRESSED_O,
   output logic [NUM_PB-1:0] PB_RELEASED_O,
   output logic [NUM_PB-1:0] PB_HELD_O
);

   localparam logic [PB_DIV_W-1:0] DIV_MAX = PB_DIV_W'(TICK_DIV);

   logic [PB_DIV_W-1:0] div_cnt;
   logic [PB_DIV_W-1:0] div_next;

   always_comb begin
      div_next = (div_cnt == DIV_MAX) ? '0 : div_cnt + 1'b1;
   end

   // Tick is registered from the next count so it is high exactly while div_cnt == DIV_MAX.
   always_ff @(posedge CLOCK_50_I) begin
      if (RESET_I) begin
         div_cnt     <= '0;
         TICK_1KHZ_O <= 1'b0;
      end else begin
         div_cnt     <= div_next;
         TICK_1KHZ_O <= (div_next == DIV_MAX);
      end
   end

   for (genvar i = 0; i < NUM_PB; i++) begin : g_chan
      pb_channel #(
         .SHIFT_LEN  (SHIFT_LEN),
         .HOLD_TICKS (HOLD_TICKS)
      ) u_chan (
         .clk      (CLOCK_50_I),
         .rst      (RESET_I),
         .tick     (TICK_1KHZ_O),
         .button_n (PUSH_BUTTON_N_I[i]),
         .status   (PB_STATUS_O[i]),
         .pressed  (PB_PRESSED_O[i]),
         .released (PB_RELEASED_O[i]),
         .held     (PB_HELD_O[i])
      );
   end

endmodule
